crt_pix_serializer: RTL and testbench
=====================================

Name: crt_pix_serializer

Overview:
- Consumer side of the CRT clock-enable scheme: accepts one 32-bit CRT-rate word per crt_clk enable and serializes it into pixels at the full pll_clock rate.
- Pixels per word follow the bpp/vga_mode decode: 4 at 8bpp, 2 at 16bpp, 1 at 32bpp/VGA.
- Sits between the CRT FIFO read port and the pixel pipeline (palette/DAC).
- Flags misaligned enable streams through sticky underrun and overrun status bits.

Parameters:
- DATA_W, 32, CRT word width; must be 32 (fixed 4-byte lane structure).
- PIX_W, 32, output pixel width; narrow pixels are zero-extended.

Ports:
- pll_clock  input  1  pixel clock; sole clock.
- reset  input  1  asynchronous, active-high reset.
- bpp  input  2  01=8bpp, 10=16bpp, 00/11=32bpp.
- vga_mode  input  1  1 forces 1 pixel per word.
- crt_clk  input  1  CRT-rate enable, synchronous to pll_clock.
- word_in  input  DATA_W  CRT data word.
- word_valid  input  1  word_in is valid; meaningful only when crt_clk=1.
- blank  input  1  display blanking.
- stat_clr  input  1  clears the sticky status bits.
- pix_out  output  PIX_W  serialized pixel.
- pix_valid  output  1  pix_out carries a real pixel.
- underrun  output  1  sticky: a pixel slot had no data.
- overrun  output  1  sticky: a word arrived before the previous word was drained.

Behaviour:
- Reset: pix_out=0, pix_valid=0, underrun=0, overrun=0, remaining count=0, shift register=0.
- Mode decode (combinational):
  - vga_mode=1 -> ppw=1.
  - bpp=01 -> ppw=4, lane 8 bits.
  - bpp=10 -> ppw=2, lane 16 bits.
  - otherwise -> ppw=1, lane 32 bits.
- Load condition: crt_clk & word_valid at a pll_clock edge.
  - Shift register <= word_in; mode latched (latched_ppw, latched_lane).
  - remaining <= ppw-1.
  - Pixel 0 (least-significant lane) is driven on pix_out in the cycle after the load edge. Latency is 1 clock.
- Drain: each following edge with remaining>0 shifts the register right by the latched lane width, decrements remaining and drives the next lane. Lane order is LSB first.
- pix_out zero-extension: 8bpp -> {24'h0, lane}; 16bpp -> {16'h0, lane}; 32bpp -> full word.
- Mode change (bpp/vga_mode) while a word is draining: no effect until the next load; the latched mode governs.
- Empty slot: an edge with remaining=0 and no load.
  - pix_out <= 0, pix_valid <= 0.
  - If blank=0, underrun <= 1.
- Missing word: crt_clk=1 with word_valid=0 and remaining=0 is an empty slot and follows the rule above.
- Overrun: a load while remaining>0.
  - The new word wins; the undrained lanes are discarded.
  - overrun <= 1.
  - The pixel-0 timing of the new word is unchanged.
- Blank=1:
  - Loads and drains proceed normally.
  - pix_out is forced to 0 and pix_valid to 0.
  - underrun is not set.
  - overrun is still detected.
- Status:
  - stat_clr=1 clears underrun and overrun.
  - A set event and stat_clr in the same cycle: the set wins.
- Steady-state alignment: with the matching CRT divider enable (1 per 4/2/1 clocks), remaining hits 0 exactly on the edge of the next load. pix_valid stays 1 continuously and neither status bit sets.
- Reset mid-word: the word is discarded immediately (async); the first load after deassertion starts cleanly.

Decomposition:
- Shared package (crt_pkg):
  - bpp encodings BPP_8=2'b01, BPP_16=2'b10, BPP_32=2'b00.
  - ppw constants PPW_8=4, PPW_16=2, PPW_32=1.
  - Function mode_to_ppw(bpp, vga_mode), also usable by the clock-enable generator so both ends share one decode.
- Sub-module: crt_lane_shifter (32-bit register, lane-width select, remaining counter). The top level holds load/underrun/overrun/blank control.

Test Plan:
- 8bpp, crt_clk every 4th clock, word_in=32'h44332211 -> pix_out 11,22,33,44 (zero-extended) on 4 consecutive clocks starting 1 clock after the load edge; pix_valid held 1; no status bits.
- 16bpp, enable every 2nd clock, words 32'hBBBBAAAA then 32'hDDDDCCCC -> pix_out AAAA,BBBB,CCCC,DDDD back-to-back; pix_valid held 1.
- vga_mode=1 with bpp=01, enable every clock, incrementing words -> each word appears unmodified 1 clock after its load; ppw=1 is confirmed.
- 8bpp, one enable with word_valid=0 and blank=0 -> 4 slots of pix_out=0, pix_valid=0; underrun=1 until stat_clr, then 0. Same stimulus with blank=1 -> underrun stays 0.
- 8bpp, second load 2 clocks after the first -> only 2 lanes of word 1 appear, then word 2 lane 0; overrun=1.
- Assert reset mid-word at 8bpp -> all outputs 0 asynchronously; after release, the next load produces its pixel 0 with correct 1-clock latency. bpp change mid-word -> the current word finishes in the old mode.

Source files
------------

// File: rtl/crt_pkg.sv
// rtl/crt_pkg.sv - shared CRT mode decode: bpp encodings, pixels-per-word, lane widths
package crt_pkg;

   localparam logic [1:0] BPP_8  = 2'b01;
   localparam logic [1:0] BPP_16 = 2'b10;
   localparam logic [1:0] BPP_32 = 2'b00;

   localparam logic [2:0] PPW_8  = 3'd4;
   localparam logic [2:0] PPW_16 = 3'd2;
   localparam logic [2:0] PPW_32 = 3'd1;

   typedef enum logic [1:0] {
      LANE_8  = 2'd0,
      LANE_16 = 2'd1,
      LANE_32 = 2'd2
   } lane_t;

   // Pixels per CRT word; the clock-enable generator uses the same decode so
   // both ends of the scheme agree on the word rate.
   function automatic logic [2:0] mode_to_ppw(input logic [1:0] bpp, input logic vga_mode);
      logic [2:0] ppw;
      ppw = PPW_32;
      if (!vga_mode) begin
         case (bpp)
            BPP_8:          ppw = PPW_8;
            BPP_16:         ppw = PPW_16;
            BPP_32, 2'b11:  ppw = PPW_32;
            default:        ppw = PPW_32;
         endcase
      end
      return ppw;
   endfunction

   // Lane width matching mode_to_ppw.
   function automatic lane_t mode_to_lane(input logic [1:0] bpp, input logic vga_mode);
      lane_t lane;
      lane = LANE_32;
      if (!vga_mode) begin
         case (bpp)
            BPP_8:   lane = LANE_8;
            BPP_16:  lane = LANE_16;
            default: lane = LANE_32;
         endcase
      end
      return lane;
   endfunction

endpackage

// File: rtl/crt_lane_shifter.sv
// rtl/crt_lane_shifter.sv - 32-bit word register that peels off lanes LSB first
module crt_lane_shifter
   import crt_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] word,
   input  logic [2:0]  ppw,
   input  lane_t       lane,
   output logic [1:0]  rem,
   output logic [31:0] data
);

   logic [31:0] shreg;
   lane_t       lane_q;

   // Load a fresh word (mode latched with it), otherwise drain one lane per clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg  <= '0;
         lane_q <= LANE_32;
         rem    <= 2'd0;
      end else if (load) begin
         shreg  <= word;
         lane_q <= lane;
         rem    <= 2'(ppw - 3'd1);
      end else if (rem != 2'd0) begin
         case (lane_q)
            LANE_8:  shreg <= shreg >> 8;
            LANE_16: shreg <= shreg >> 16;
            default: shreg <= shreg;
         endcase
         rem <= rem - 2'd1;
      end
   end

   // Current lane, zero-extended to a full word.
   always_comb begin
      data = shreg;
      case (lane_q)
         LANE_8:  data = {24'h0, shreg[7:0]};
         LANE_16: data = {16'h0, shreg[15:0]};
         default: data = shreg;
      endcase
   end

endmodule

// File: rtl/crt_pix_serializer.sv
// rtl/crt_pix_serializer.sv - serializes CRT-rate words into pll_clock-rate pixels
module crt_pix_serializer
   import crt_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PIX_W  = 32
) (
   input  logic              pll_clock,
   input  logic              reset,
   input  logic [1:0]        bpp,
   input  logic              vga_mode,
   input  logic              crt_clk,
   input  logic [DATA_W-1:0] word_in,
   input  logic              word_valid,
   input  logic              blank,
   input  logic              stat_clr,
   output logic [PIX_W-1:0]  pix_out,
   output logic              pix_valid,
   output logic              underrun,
   output logic              overrun
);

   logic        load;
   logic        empty;
   logic [1:0]  rem;
   logic [31:0] lane_data;
   logic        slot_full;
   logic        blank_q;

   assign load  = crt_clk & word_valid;
   assign empty = !load && (rem == 2'd0);

   crt_lane_shifter u_shifter (
      .clk  (pll_clock),
      .rst  (reset),
      .load (load),
      .word (word_in),
      .ppw  (mode_to_ppw(bpp, vga_mode)),
      .lane (mode_to_lane(bpp, vga_mode)),
      .rem  (rem),
      .data (lane_data)
   );

   // Track whether the slot following this edge carries a pixel, and its blanking.
   always_ff @(posedge pll_clock or posedge reset) begin
      if (reset) begin
         slot_full <= 1'b0;
         blank_q   <= 1'b0;
      end else begin
         slot_full <= !empty;
         blank_q   <= blank;
      end
   end

   // Sticky status; a set event beats a simultaneous clear.
   always_ff @(posedge pll_clock or posedge reset) begin
      if (reset) begin
         underrun <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (empty && !blank) underrun <= 1'b1;
         else if (stat_clr)   underrun <= 1'b0;
         if (load && rem != 2'd0) overrun <= 1'b1;
         else if (stat_clr)       overrun <= 1'b0;
      end
   end

   assign pix_valid = slot_full & ~blank_q;
   assign pix_out   = pix_valid ? PIX_W'(lane_data) : '0;

endmodule

// File: tb/tb_crt_pix_serializer.sv
// tb/tb_crt_pix_serializer.sv - self-checking bench for crt_pix_serializer
module tb_crt_pix_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  bpp;
   logic        vga_mode;
   logic        crt_clk;
   logic [31:0] word_in;
   logic        word_valid;
   logic        blank;
   logic        stat_clr;
   logic [31:0] pix_out;
   logic        pix_valid;
   logic        underrun;
   logic        overrun;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_pix   = '0;
   logic        exp_valid = 1'b0;
   logic        exp_under = 1'b0;
   logic        exp_over  = 1'b0;

   crt_pix_serializer dut (
      .pll_clock  (clk),
      .reset      (reset),
      .bpp        (bpp),
      .vga_mode   (vga_mode),
      .crt_clk    (crt_clk),
      .word_in    (word_in),
      .word_valid (word_valid),
      .blank      (blank),
      .stat_clr   (stat_clr),
      .pix_out    (pix_out),
      .pix_valid  (pix_valid),
      .underrun   (underrun),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_assert++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic check_all();
      check("pix_out", pix_out, exp_pix);
      check("pix_valid", 32'(pix_valid), 32'(exp_valid));
      check("underrun", 32'(underrun), 32'(exp_under));
      check("overrun", 32'(overrun), 32'(exp_over));
   endtask

   // Reference: a word becomes a queue of pixels; each clock emits the head.
   task automatic model_edge();
      logic        us;
      logic        os;
      logic [31:0] p;
      int          n;
      int          w;
      logic [31:0] mask;
      us = 1'b0;
      os = 1'b0;
      if (crt_clk && word_valid) begin
         os = (exp_q.size() != 0);
         exp_q.delete();
         n = vga_mode ? 1 : (bpp == 2'b01 ? 4 : (bpp == 2'b10 ? 2 : 1));
         w = 32 / n;
         mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
         for (int i = 0; i < n; i++) exp_q.push_back((word_in >> (i * w)) & mask);
      end
      if (exp_q.size() != 0) begin
         p = exp_q.pop_front();
         exp_valid = !blank;
         exp_pix   = blank ? 32'h0 : p;
      end else begin
         exp_valid = 1'b0;
         exp_pix   = 32'h0;
         us        = !blank;
      end
      exp_under = us ? 1'b1 : (stat_clr ? 1'b0 : exp_under);
      exp_over  = os ? 1'b1 : (stat_clr ? 1'b0 : exp_over);
   endtask

   task automatic cyc(input logic c, input logic v, input logic [31:0] w, input logic b, input logic clr);
      crt_clk    = c;
      word_valid = v;
      word_in    = w;
      blank      = b;
      stat_clr   = clr;
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      logic [31:0] rw;
      reset = 1'b1; bpp = 2'b01; vga_mode = 1'b0; crt_clk = 1'b0;
      word_in = '0; word_valid = 1'b0; blank = 1'b0; stat_clr = 1'b0;
      #12;
      check("rst_pix_out", pix_out, 32'h0);
      check("rst_pix_valid", 32'(pix_valid), 32'h0);
      check("rst_underrun", 32'(underrun), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      // 8bpp steady stream
      cyc(1, 1, 32'h44332211, 0, 0); check("8bpp_l0", pix_out, 32'h11);
      cyc(0, 0, 0, 0, 0);            check("8bpp_l1", pix_out, 32'h22);
      cyc(0, 0, 0, 0, 0);            check("8bpp_l2", pix_out, 32'h33);
      cyc(0, 0, 0, 0, 0);            check("8bpp_l3", pix_out, 32'h44);
      cyc(1, 1, $urandom, 0, 0);     check("8bpp_valid", 32'(pix_valid), 32'h1);
      repeat (3) cyc(0, 0, 0, 0, 0);
      check("8bpp_no_status", {30'h0, underrun, overrun}, 32'h0);

      // 16bpp back to back
      bpp = 2'b10;
      cyc(1, 1, 32'hBBBBAAAA, 0, 0); check("16bpp_a", pix_out, 32'hAAAA);
      cyc(0, 0, 0, 0, 0);            check("16bpp_b", pix_out, 32'hBBBB);
      cyc(1, 1, 32'hDDDDCCCC, 0, 0); check("16bpp_c", pix_out, 32'hCCCC);
      cyc(0, 0, 0, 0, 0);            check("16bpp_d", pix_out, 32'hDDDD);
      check("16bpp_no_status", {30'h0, underrun, overrun}, 32'h0);

      // VGA forces one pixel per word
      bpp = 2'b01; vga_mode = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc(1, 1, 32'h8070_6050 + 32'(k), 0, 0);
         check("vga_word", pix_out, 32'h8070_6050 + 32'(k));
      end
      vga_mode = 1'b0;

      // Missing word: underrun, then clear on a load cycle
      cyc(1, 0, 0, 0, 0); check("miss_valid", 32'(pix_valid), 32'h0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      check("miss_underrun", 32'(underrun), 32'h1);
      cyc(1, 1, $urandom, 0, 1); check("clr_underrun", 32'(underrun), 32'h0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      // Same with blanking: no underrun
      cyc(1, 0, 0, 1, 0);
      repeat (3) cyc(0, 0, 0, 1, 0);
      check("blank_underrun", 32'(underrun), 32'h0);

      // Overrun: second load two clocks after the first
      cyc(1, 1, 32'h0D0C0B0A, 0, 0); check("ovr_a0", pix_out, 32'h0A);
      cyc(0, 0, 0, 0, 0);            check("ovr_a1", pix_out, 32'h0B);
      cyc(1, 1, 32'h1D1C1B1A, 0, 0); check("ovr_b0", pix_out, 32'h1A);
      check("ovr_flag", 32'(overrun), 32'h1);
      repeat (3) cyc(0, 0, 0, 0, 0);
      cyc(1, 1, $urandom, 0, 1);     check("clr_overrun", 32'(overrun), 32'h0);
      repeat (3) cyc(0, 0, 0, 0, 0);

      // Asynchronous reset mid-word
      cyc(1, 1, 32'h55667788, 0, 0);
      cyc(0, 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      exp_q.delete();
      exp_pix = '0; exp_valid = 1'b0; exp_under = 1'b0; exp_over = 1'b0;
      check("async_rst_pix", pix_out, 32'h0);
      check("async_rst_valid", 32'(pix_valid), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      cyc(1, 1, 32'hCAFEF00D, 0, 0); check("post_rst_l0", pix_out, 32'h0D);
      check("post_rst_ovr", 32'(overrun), 32'h0);
      repeat (3) cyc(0, 0, 0, 0, 0);

      // Mode change mid-word keeps the latched mode
      cyc(1, 1, 32'hA1B2C3D4, 0, 0); check("mchg_l0", pix_out, 32'hD4);
      bpp = 2'b10;
      cyc(0, 0, 0, 0, 0);            check("mchg_l1", pix_out, 32'hC3);
      cyc(0, 0, 0, 0, 0);            check("mchg_l2", pix_out, 32'hB2);
      cyc(0, 0, 0, 0, 0);            check("mchg_l3", pix_out, 32'hA1);
      cyc(1, 1, 32'h12345678, 0, 0); check("mchg_new", pix_out, 32'h5678);

      // Randomized traffic against the reference queue model
      for (int i = 0; i < 300; i++) begin
         bpp      = 2'($urandom);
         vga_mode = ($urandom_range(0, 7) == 0);
         rw       = $urandom;
         cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 4) != 0), rw,
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
